// File: rtl/serial_subtractor_8bit_pkg.sv
// Shared definitions for the bit-serial subtractor: default width, FSM state
// encodings and the bit-counter sizing helper.
package serial_subtractor_8bit_pkg;

    localparam int WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Keep the counter at least one bit wide for degenerate widths.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W = cnt_width(WIDTH);

endpackage

// File: rtl/serial_subtractor_8bit_fullsub.sv
// Combinational full-subtractor cell: d = a - b - bin, with borrow-out.
module serial_subtractor_8bit_fullsub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first,
// with a start/busy/done handshake around a single reused full-subtractor cell.
module serial_subtractor_8bit
    import serial_subtractor_8bit_pkg::*;
#(
    parameter int WIDTH = serial_subtractor_8bit_pkg::WIDTH
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state_r;
    state_e           state_nxt_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] diff_r;
    logic [CW-1:0]    cnt_r;
    logic             br_r;
    logic             bout_r;
    logic             busy_r;
    logic             done_r;
    logic             d_s;
    logic             br_nxt_s;
    logic             last_bit_s;

    serial_subtractor_8bit_fullsub u_fullsub (
        .a    (a_sh_r[0]),
        .b    (b_sh_r[0]),
        .bin  (br_r),
        .d    (d_s),
        .bout (br_nxt_s)
    );

    assign last_bit_s = (cnt_r == CW'(WIDTH - 1));

    // Next-state logic: start is only honoured in IDLE; DONE lasts one cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_bit_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register and registered handshake outputs.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == SHIFT);
            done_r  <= (state_nxt_s == DONE);
        end
    end

    // Datapath: capture operands on accept, then consume one bit per SHIFT edge.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            a_sh_r <= {WIDTH{1'b0}};
            b_sh_r <= {WIDTH{1'b0}};
            diff_r <= {WIDTH{1'b0}};
            cnt_r  <= {CW{1'b0}};
            br_r   <= 1'b0;
            bout_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_sh_r <= a;
                        b_sh_r <= b;
                        br_r   <= bin;
                        cnt_r  <= {CW{1'b0}};
                    end
                end
                SHIFT: begin
                    // diff fills from the MSB so the LSB lands at bit 0 last.
                    diff_r <= {d_s, diff_r[WIDTH-1:1]};
                    a_sh_r <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
                    br_r   <= br_nxt_s;
                    cnt_r  <= cnt_r + CW'(1);
                    if (last_bit_s) begin
                        bout_r <= br_nxt_s;
                    end
                end
                DONE: begin
                    diff_r <= diff_r;
                end
                default: begin
                    diff_r <= diff_r;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign diff = diff_r;
    assign bout = bout_r;

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// Scoreboard bench for serial_subtractor_8bit: stimulus pushes expected
// {bout,diff}; a negedge monitor pops and compares on every done pulse.
module tb_serial_subtractor_8bit;

    logic       clock;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;

    int checks;
    int failures;
    int edge_cnt;
    int busy_run;
    int last_done_edge;
    bit have_last;
    bit check_period;
    bit prev_done;

    logic [8:0] exp_q[$];

    serial_subtractor_8bit dut (
        .clock (clock),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    // Monitor: result, latency, pulse width and repetition period.
    always @(negedge clock) begin
        if (rst) begin
            busy_run  = 0;
            prev_done = 1'b0;
        end else begin
            if (busy) busy_run = busy_run + 1;
            if (done) begin
                logic [8:0] e;
                checks = checks + 1;
                if (exp_q.size() == 0) begin
                    failures = failures + 1;
                    $display("FAIL unexpected_done: got diff=%h bout=%b, no result expected", diff, bout);
                end else begin
                    e = exp_q.pop_front();
                    if ({bout, diff} !== e || busy !== 1'b0) begin
                        failures = failures + 1;
                        $display("FAIL result: got bout=%b diff=%h busy=%b, expected bout=%b diff=%h busy=0",
                                 bout, diff, busy, e[8], e[7:0]);
                    end
                end
                checks = checks + 1;
                if (busy_run != 8) begin
                    failures = failures + 1;
                    $display("FAIL latency: busy cycles before done=%0d, expected 8", busy_run);
                end
                if (check_period && have_last) begin
                    checks = checks + 1;
                    if (edge_cnt - last_done_edge != 10) begin
                        failures = failures + 1;
                        $display("FAIL period: done spacing=%0d, expected 10", edge_cnt - last_done_edge);
                    end
                end
                last_done_edge = edge_cnt;
                have_last      = 1'b1;
                busy_run       = 0;
            end
            if (done && prev_done) begin
                failures = failures + 1;
                $display("FAIL done_width: done high on consecutive cycles, expected single pulse");
            end
            prev_done = done;
        end
    end

    // Present an operation while the DUT is idle; returns 1ns after the accept edge.
    task automatic issue(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin,
                         input logic [8:0] expv);
        a     = ta;
        b     = tb_v;
        bin   = tbin;
        start = 1'b1;
        exp_q.push_back(expv);
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            checks   = checks + 1;
            failures = failures + 1;
            $display("FAIL timeout: done not seen within 40 cycles, expected done");
        end
    endtask

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin,
                          input logic [8:0] expv);
        issue(ta, tb_v, tbin, expv);
        wait_done();
        @(posedge clock);
        #1;
    endtask

    task automatic check_zero(input string name);
        checks = checks + 1;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || bout !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL %s: got busy=%b done=%b diff=%h bout=%b, expected all zero",
                     name, busy, done, diff, bout);
        end
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rbin;
        logic [8:0] rref;
        checks = 0; failures = 0; edge_cnt = 0; busy_run = 0;
        last_done_edge = 0; have_last = 1'b0; check_period = 1'b0; prev_done = 1'b0;
        rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; bin = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_zero("reset_state");

        // Release reset with start already high: accepted on the first edge.
        rst = 1'b0;
        issue(8'h05, 8'h03, 1'b0, {1'b0, 8'h02});
        wait_done();
        @(posedge clock); #1;

        run_op(8'h03, 8'h05, 1'b0, {1'b1, 8'hFE});
        run_op(8'h00, 8'h00, 1'b1, {1'b1, 8'hFF});

        // Operands change right after acceptance; result must not move.
        issue(8'hFF, 8'h01, 1'b1, {1'b0, 8'hFD});
        a = 8'h00; b = 8'h00; bin = 1'b0;
        wait_done();
        @(posedge clock); #1;

        // A start pulse mid-operation must be ignored.
        issue(8'h5A, 8'h3C, 1'b0, {1'b0, 8'h1E});
        repeat (3) @(posedge clock);
        #1;
        a = 8'hFF; b = 8'h00; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        wait_done();
        @(posedge clock); #1;

        // start held high: back-to-back operations every 10 cycles.
        have_last = 1'b0;
        check_period = 1'b1;
        a = 8'h10; b = 8'h01; bin = 1'b0;
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, 8'h0F});
        start = 1'b1;
        for (int i = 0; i < 3; i++) wait_done();
        start = 1'b0;
        check_period = 1'b0;
        @(posedge clock); #1;

        // Asynchronous reset between SHIFT edges aborts the operation.
        issue(8'h33, 8'h11, 1'b0, {1'b0, 8'h22});
        repeat (4) @(posedge clock);
        #2;
        rst = 1'b1;
        #1;
        check_zero("abort_reset");
        exp_q.delete();
        @(posedge clock); #1;
        rst = 1'b0;
        repeat (12) @(posedge clock);
        #1;
        check_zero("no_done_after_abort");
        run_op(8'h80, 8'h7F, 1'b0, {1'b0, 8'h01});

        for (int i = 0; i < 1000; i++) begin
            ra   = 8'($urandom_range(0, 255));
            rb   = 8'($urandom_range(0, 255));
            rbin = 1'($urandom_range(0, 1));
            rref = {1'b0, ra} - {1'b0, rb} - {8'h00, rbin};
            run_op(ra, rb, rbin, rref);
        end

        checks = checks + 1;
        if (exp_q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
